// File: rtl/input_activation_ctrl_if.sv
// Host-side command/write bus and compute-side activation stream of the feeder.
// The host drives the commands and write data; the feeder drives flags and slices.
interface input_activation_ctrl_if #(
    parameter int INPUT_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 8
);
    logic                    CLEAR_FIFO;
    logic                    START_FEED;
    logic                    FIFO_WR_CMD;
    logic [INPUT_WIDTH-1:0]  FIFO_WR_DATA;
    logic                    FIFO_EMPTY;
    logic                    FIFO_FULL;
    logic [OUTPUT_WIDTH-1:0] IN_ACT_DATA_OUT;
    logic                    DATA_VALID;

    modport master (
        output CLEAR_FIFO,
        output START_FEED,
        output FIFO_WR_CMD,
        output FIFO_WR_DATA,
        input  FIFO_EMPTY,
        input  FIFO_FULL,
        input  IN_ACT_DATA_OUT,
        input  DATA_VALID
    );

    modport slave (
        input  CLEAR_FIFO,
        input  START_FEED,
        input  FIFO_WR_CMD,
        input  FIFO_WR_DATA,
        output FIFO_EMPTY,
        output FIFO_FULL,
        output IN_ACT_DATA_OUT,
        output DATA_VALID
    );
endinterface

// File: rtl/input_activation_ctrl.sv
// Buffers host words in a circular FIFO and streams them LSB-slice first, one slice per clock.
// Latency: first slice in the cycle after START_FEED is sampled; writes to a full FIFO are dropped.
module input_activation_ctrl #(
    parameter int INPUT_WIDTH  = 32,
    parameter int FIFO_DEPTH   = 64,
    parameter int OUTPUT_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input_activation_ctrl_if.slave bus
);
    localparam int RATIO = INPUT_WIDTH / OUTPUT_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        FEED = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [INPUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic [IDX_W-1:0]       idx_q;

    logic                   empty;
    logic                   full;
    logic                   feeding;
    logic                   last_slice;
    logic                   pop;
    logic                   wr_en;
    logic [INPUT_WIDTH-1:0] head;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_FULL);
    assign feeding    = (state_q == FEED) && !empty;
    assign last_slice = (idx_q == IDX_LAST);
    assign pop        = feeding && last_slice;
    assign wr_en      = bus.FIFO_WR_CMD && !full;

    // State register
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave FEED only once the FIFO is (or is about to be) empty; START_FEED is a pulse
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.START_FEED && !empty) begin
                    state_d = FEED;
                end
            end
            FEED: begin
                if (empty) begin
                    state_d = IDLE;
                end else if (pop && !wr_en && (count_q == CNT_ONE)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.CLEAR_FIFO) begin
            state_d = IDLE;
        end
    end

    // Pointers, occupancy and slice index; power-of-two depth gives free wrap
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
        end else if (bus.CLEAR_FIFO) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (feeding) begin
                idx_q <= last_slice ? '0 : idx_q + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; stale words are unreachable once the pointers are cleared
    always_ff @(posedge CLK) begin
        if (wr_en && !bus.CLEAR_FIFO) begin
            mem[wr_ptr_q] <= bus.FIFO_WR_DATA;
        end
    end

    assign head = mem[rd_ptr_q];

    assign bus.FIFO_EMPTY      = empty;
    assign bus.FIFO_FULL       = full;
    assign bus.DATA_VALID      = feeding;
    assign bus.IN_ACT_DATA_OUT = feeding ? head[int'(idx_q) * OUTPUT_WIDTH +: OUTPUT_WIDTH]
                                         : '0;
endmodule

// File: tb/tb_input_activation_ctrl.sv
// Directed bench for input_activation_ctrl: queue-level reference model checked every cycle,
// plus stream reassembly and hand-computed slice expectations.
module tb_input_activation_ctrl;
    localparam int IW    = 32;
    localparam int OW    = 8;
    localparam int DEPTH = 64;
    localparam int R     = IW / OW;

    logic clk;
    logic rstn;

    input_activation_ctrl_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

    input_activation_ctrl #(
        .INPUT_WIDTH (IW),
        .FIFO_DEPTH  (DEPTH),
        .OUTPUT_WIDTH(OW)
    ) dut (
        .CLK   (clk),
        .RESETN(rstn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word queue, a feeding flag and a slice position
    logic [IW-1:0] mq[$];
    bit            m_feed;
    int            m_idx;
    bit            m_was_empty;
    bit            m_was_full;

    always @(posedge clk or negedge rstn) begin
        if (!rstn || bus.CLEAR_FIFO) begin
            mq.delete();
            m_feed = 1'b0;
            m_idx  = 0;
        end else begin
            m_was_empty = (mq.size() == 0);
            m_was_full  = (mq.size() == DEPTH);
            if (m_feed && !m_was_empty) begin
                if (m_idx == R - 1) begin
                    void'(mq.pop_front());
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
            if (bus.FIFO_WR_CMD && !m_was_full) mq.push_back(bus.FIFO_WR_DATA);
            if (!m_feed) m_feed = bus.START_FEED && !m_was_empty;
            else         m_feed = !m_was_empty && (mq.size() != 0);
        end
    end

    // Per-cycle compare plus stream capture
    logic [7:0]    got[$];
    int            rises;
    bit            prev_v;
    bit            exp_valid;
    logic [IW-1:0] exp_head;
    logic [OW-1:0] exp_data;

    always @(negedge clk) begin
        exp_valid = m_feed && (mq.size() != 0);
        exp_data  = '0;
        if (exp_valid) begin
            exp_head = mq[0];
            exp_data = exp_head[m_idx*OW +: OW];
        end
        check("cyc_empty", {31'b0, bus.FIFO_EMPTY}, {31'b0, mq.size() == 0});
        check("cyc_full",  {31'b0, bus.FIFO_FULL},  {31'b0, mq.size() == DEPTH});
        check("cyc_valid", {31'b0, bus.DATA_VALID}, {31'b0, exp_valid});
        check("cyc_data",  {24'b0, bus.IN_ACT_DATA_OUT}, {24'b0, exp_data});
        if (bus.DATA_VALID === 1'b1) begin
            got.push_back(bus.IN_ACT_DATA_OUT);
            if (!prev_v) rises++;
        end
        prev_v = (bus.DATA_VALID === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [IW-1:0] w);
        bus.FIFO_WR_CMD  = 1'b1;
        bus.FIFO_WR_DATA = w;
        tick();
        bus.FIFO_WR_CMD  = 1'b0;
    endtask

    task automatic start_pulse(input int n);
        bus.START_FEED = 1'b1;
        repeat (n) tick();
        bus.START_FEED = 1'b0;
    endtask

    task automatic reset_capture();
        got.delete();
        rises = 0;
    endtask

    task automatic check_words(input string name, input logic [IW-1:0] w[$]);
        logic [IW-1:0] a;
        check({name, "_len"}, got.size(), w.size() * R);
        for (int k = 0; k < w.size() && (k * R + R - 1) < got.size(); k++) begin
            a = {got[k*R+3], got[k*R+2], got[k*R+1], got[k*R]};
            check({name, "_word"}, a, w[k]);
        end
        check({name, "_runs"}, rises, (w.size() != 0) ? 1 : 0);
    endtask

    logic [IW-1:0] wl[$];
    int            n;

    initial begin
        rstn             = 1'b0;
        bus.CLEAR_FIFO   = 1'b0;
        bus.START_FEED   = 1'b0;
        bus.FIFO_WR_CMD  = 1'b0;
        bus.FIFO_WR_DATA = '0;
        rises            = 0;
        prev_v           = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_empty", {31'b0, bus.FIFO_EMPTY}, 32'd1);
        check("rst_full",  {31'b0, bus.FIFO_FULL},  32'd0);
        check("rst_valid", {31'b0, bus.DATA_VALID}, 32'd0);
        check("rst_data",  {24'b0, bus.IN_ACT_DATA_OUT}, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Fill with gaps, then drain
        wl.delete();
        for (int k = 0; k < 21; k++) begin
            wl.push_back($urandom);
            write_word(wl[k]);
            repeat ($urandom_range(0, 3)) tick();
        end
        reset_capture();
        start_pulse($urandom_range(1, 4));
        repeat (84 + 8) tick();
        check_words("fill_drain", wl);
        @(negedge clk);
        check("fd_end_empty", {31'b0, bus.FIFO_EMPTY}, 32'd1);
        check("fd_end_valid", {31'b0, bus.DATA_VALID}, 32'd0);

        // Full boundary and dropped write
        wl.delete();
        for (int k = 0; k < DEPTH; k++) begin
            wl.push_back(32'h1000_0000 + k);
            write_word(wl[k]);
        end
        @(negedge clk);
        check("full_after_64", {31'b0, bus.FIFO_FULL}, 32'd1);
        write_word(32'hDEAD_BEEF);
        @(negedge clk);
        check("full_after_drop", {31'b0, bus.FIFO_FULL}, 32'd1);
        reset_capture();
        start_pulse(1);
        repeat (DEPTH * R + 6) tick();
        check_words("full_drain", wl);
        check("full_last_word", {got[255], got[254], got[253], got[252]}, 32'h1000_003F);

        // Start with empty FIFO is ignored
        reset_capture();
        start_pulse(3);
        write_word(32'h1122_3344);
        repeat (3) tick();
        @(negedge clk);
        check("empty_start_valid", {31'b0, bus.DATA_VALID}, 32'd0);
        check("empty_start_none", got.size(), 32'd0);
        bus.START_FEED = 1'b1;
        tick();
        bus.START_FEED = 1'b0;
        @(negedge clk);
        check("slice0", {24'b0, bus.IN_ACT_DATA_OUT}, 32'h44);
        tick(); @(negedge clk);
        check("slice1", {24'b0, bus.IN_ACT_DATA_OUT}, 32'h33);
        tick(); @(negedge clk);
        check("slice2", {24'b0, bus.IN_ACT_DATA_OUT}, 32'h22);
        tick(); @(negedge clk);
        check("slice3", {24'b0, bus.IN_ACT_DATA_OUT}, 32'h11);
        tick(); @(negedge clk);
        check("after_last_valid", {31'b0, bus.DATA_VALID}, 32'd0);
        check("after_last_empty", {31'b0, bus.FIFO_EMPTY}, 32'd1);

        // Concurrent writes during a feed
        wl.delete();
        for (int k = 0; k < 4; k++) begin
            wl.push_back(32'h5500_0000 + k);
            write_word(wl[k]);
        end
        reset_capture();
        start_pulse(1);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (mq.size() < DEPTH) begin
                wl.push_back(32'hA0A0_A0A0 + n);
                n++;
                bus.FIFO_WR_CMD  = 1'b1;
                bus.FIFO_WR_DATA = 32'hA0A0_A0A0 + n - 1;
            end else begin
                bus.FIFO_WR_CMD = 1'b0;
            end
            tick();
        end
        bus.FIFO_WR_CMD = 1'b0;
        for (int c = 0; c < 600 && mq.size() != 0; c++) tick();
        repeat (3) tick();
        check("conc_drained", {31'b0, bus.FIFO_EMPTY}, 32'd1);
        check_words("concurrent", wl);

        // Clear in the middle of word 2, slice 1
        write_word(32'h0302_0100);
        write_word(32'h1312_1110);
        write_word(32'h2322_2120);
        start_pulse(1);
        repeat (9) tick();
        @(negedge clk);
        check("pre_clear_slice", {24'b0, bus.IN_ACT_DATA_OUT}, 32'h21);
        bus.CLEAR_FIFO = 1'b1;
        tick();
        bus.CLEAR_FIFO = 1'b0;
        @(negedge clk);
        check("clear_empty", {31'b0, bus.FIFO_EMPTY}, 32'd1);
        check("clear_valid", {31'b0, bus.DATA_VALID}, 32'd0);
        write_word(32'hCAFE_F00D);
        start_pulse(1);
        @(negedge clk);
        check("post_clear_s0", {24'b0, bus.IN_ACT_DATA_OUT}, 32'h0D);
        tick(); @(negedge clk);
        check("post_clear_s1", {24'b0, bus.IN_ACT_DATA_OUT}, 32'hF0);
        repeat (4) tick();

        // Asynchronous reset mid-feed
        write_word(32'h7766_5544);
        write_word(32'hBBAA_9988);
        start_pulse(1);
        tick();
        #2 rstn = 1'b0;
        #1;
        check("arst_empty", {31'b0, bus.FIFO_EMPTY}, 32'd1);
        check("arst_full",  {31'b0, bus.FIFO_FULL},  32'd0);
        check("arst_valid", {31'b0, bus.DATA_VALID}, 32'd0);
        check("arst_data",  {24'b0, bus.IN_ACT_DATA_OUT}, 32'd0);
        tick();
        rstn = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
